load_store_unit: RTL and testbench

//  Memory-access stage directly downstream of the core's EXECUTE state; services isLoad/isStore.

---
 rtl/load_store_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage that sits after the core's EXECUTE state. It accepts
//   one load/store at a time. It drives a word-wide memory bus with byte-lane
//   write masks and waits a variable number of cycles for mem_ack. It then
//   returns sign- or zero-extended load data as a single-cycle response.
//   Misaligned accesses, illegal funct3 codes and bus timeouts set resp_err.
//
// Ports
//   clk_i          system clock, all state updates on the rising edge
//   resetn_i       asynchronous active-low reset
//   req_valid_i    core presents an access this cycle
//   req_ready_o    unit is idle; request accepted when valid & ready
//   req_store_i    1 = store, 0 = load
//   req_funct3_i   instr[14:12]: access size / signedness
//   req_addr_i     byte address
//   req_wdata_i    store data (rs2)
//   resp_valid_o   one-cycle pulse, access finished
//   resp_rdata_o   extended load data (0 for stores and errors)
//   resp_err_o     misaligned, illegal funct3 or timeout; qualified by resp_valid_o
//   mem_req_o      bus request, held until mem_ack_i or timeout
//   mem_we_o       1 = write
//   mem_addr_o     word address (byte address [ADDR_WIDTH-1:2])
//   mem_wmask_o    byte-lane write enables (0 on reads)
//   mem_wdata_o    lane-replicated store data
//   mem_ack_i      bus completion; read data valid in the same cycle
//   mem_rdata_i    read word
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_store_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-3:0] mem_addr_o,
    output logic [3:0]            mem_wmask_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-3:0]   mem_addr_q, mem_addr_d;
    logic [3:0]              mem_wmask_q, mem_wmask_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    // Request decode: legality, alignment, store lane mask and data.
    logic        req_legal;
    logic        req_aligned;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;

    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b1;
        st_mask     = 4'b0000;
        st_wdata    = req_wdata_i;
        if (req_store_i) begin
            req_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                        (req_funct3_i == 3'b010);
        end else begin
            req_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                        (req_funct3_i == 3'b010) || (req_funct3_i == 3'b100) ||
                        (req_funct3_i == 3'b101);
        end
        // funct3[1:0] encodes the size for both loads and stores.
        case (req_funct3_i[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << req_addr_i[1:0];
                st_wdata = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_aligned = ~req_addr_i[0];
                st_mask     = req_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata    = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                req_aligned = (req_addr_i[1:0] == 2'b00);
                st_mask     = 4'b1111;
            end
            default: begin
                req_aligned = 1'b1;
            end
        endcase
    end

    // Load extraction from the returned word, using the offset and funct3
    // captured at accept time.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
        ld_half = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    funct3_d = req_funct3_i;
                    off_d    = req_addr_i[1:0];
                    cnt_d    = '0;
                    if (req_legal && req_aligned) begin
                        state_d      = S_BUS;
                        mem_req_d    = 1'b1;
                        mem_we_d     = req_store_i;
                        mem_addr_d   = req_addr_i[ADDR_WIDTH-1:2];
                        mem_wmask_d  = req_store_i ? st_mask : 4'b0000;
                        mem_wdata_d  = req_store_i ? st_wdata : 32'd0;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b0;
                    end else begin
                        // Rejected without touching the bus.
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            S_BUS: begin
                // An ack in the same cycle that the timeout would expire still counts as completion.
                if (mem_ack_i) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_we_q ? 32'd0 : ld_data;
                    resp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // This is the TIMEOUT-th request cycle without an ack, so abort now.
                    if (cnt_q == CNT_LAST) begin
                        state_d      = S_RESP;
                        mem_req_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wmask_q  <= 4'b0000;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wmask_o  = mem_wmask_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed-vector bench for load_store_unit with hand-computed expectations.
//   Stimulus is driven on the falling edge and outputs are sampled on the
//   falling edge. Each access prints one line.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(15)) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_store_i  (req_store),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wmask_o  (mem_wmask),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations from the most recent access.
    logic        r_acc_ready;
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_req_cycles;
    int          r_lat;
    logic        r_we;
    logic [29:0] r_addr;
    logic [3:0]  r_mask;
    logic [31:0] r_wdata;
    logic        r_busy_ready;
    logic        r_pulse_ok;

    // Issues one request and plays the memory side. ack_at = k acks in the
    // k-th mem_req cycle (0 = never ack). Latency is counted in cycles from accept.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        r_acc_ready  = req_ready;
        r_req_cycles = 0;
        r_lat        = -1;
        r_busy_ready = 1'b0;
        r_rdata      = 32'hxxxxxxxx;
        r_err        = 1'bx;
        r_we         = 1'bx;
        r_addr       = 'x;
        r_mask       = 4'bxxxx;
        r_wdata      = 32'hxxxxxxxx;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = 32'd0;
            if (req_ready) r_busy_ready = 1'b1;
            if (mem_req) begin
                r_req_cycles++;
                if (r_req_cycles == 1) begin
                    r_we    = mem_we;
                    r_addr  = mem_addr;
                    r_mask  = mem_wmask;
                    r_wdata = mem_wdata;
                end
            end
            if (resp_valid) begin
                r_lat   = i;
                r_rdata = resp_rdata;
                r_err   = resp_err;
                break;
            end
            if (mem_req && r_req_cycles == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
        end
        @(negedge clk);
        mem_ack    = 1'b0;
        r_pulse_ok = ~resp_valid;
        $display("[TB] access st=%0b f3=%03b addr=%08h wd=%08h -> lat=%0d reqcyc=%0d rdata=%08h err=%0b mask=%04b mwdata=%08h",
                 st, f3, addr, wd, r_lat, r_req_cycles, r_rdata, r_err, r_mask, r_wdata);
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        tests_run++;
        if ({resp_valid, resp_err, mem_req, mem_we, mem_wmask} !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000000", {resp_valid, resp_err, mem_req, mem_we, mem_wmask});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, resp_rdata} !== 94'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want all 0", mem_addr, mem_wdata, resp_rdata);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_word();
        access(1'b0, 3'b010, 32'h100, 32'd0, 1, 32'hDEADBEEF);
        tests_run++;
        if (r_acc_ready !== 1'b1) begin tests_failed++; $display("FAIL lw_ready: got %b want 1", r_acc_ready); end
        tests_run++;
        if (r_addr !== 30'h40) begin tests_failed++; $display("FAIL lw_addr: got %h want 40", r_addr); end
        tests_run++;
        if ({r_we, r_mask} !== 5'b00000) begin tests_failed++; $display("FAIL lw_we_mask: got %b want 00000", {r_we, r_mask}); end
        tests_run++;
        if (r_lat !== 2) begin tests_failed++; $display("FAIL lw_latency: got %0d want 2", r_lat); end
        tests_run++;
        if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0) begin
            tests_failed++; $display("FAIL lw_rdata: got %h err %b want deadbeef err 0", r_rdata, r_err);
        end
        tests_run++;
        if (r_pulse_ok !== 1'b1 || r_busy_ready !== 1'b0) begin
            tests_failed++; $display("FAIL lw_handshake: pulse_ok %b busy_ready %b want 1 0", r_pulse_ok, r_busy_ready);
        end
    endtask

    task automatic test_load_extend();
        access(1'b0, 3'b000, 32'h103, 32'd0, 3, 32'h80123456);
        tests_run++;
        if (r_rdata !== 32'hFFFFFF80 || r_err !== 1'b0) begin
            tests_failed++; $display("FAIL lb_sext: got %h err %b want ffffff80 err 0", r_rdata, r_err);
        end
        tests_run++;
        if (r_lat !== 4) begin tests_failed++; $display("FAIL lb_latency: got %0d want 4", r_lat); end
        access(1'b0, 3'b100, 32'h103, 32'd0, 3, 32'h80123456);
        tests_run++;
        if (r_rdata !== 32'h00000080) begin tests_failed++; $display("FAIL lbu_zext: got %h want 00000080", r_rdata); end
        access(1'b0, 3'b001, 32'h102, 32'd0, 2, 32'h80123456);
        tests_run++;
        if (r_rdata !== 32'hFFFF8012) begin tests_failed++; $display("FAIL lh_sext: got %h want ffff8012", r_rdata); end
        access(1'b0, 3'b101, 32'h102, 32'd0, 1, 32'h80123456);
        tests_run++;
        if (r_rdata !== 32'h00008012) begin tests_failed++; $display("FAIL lhu_zext: got %h want 00008012", r_rdata); end
        access(1'b0, 3'b000, 32'h100, 32'd0, 1, 32'h80123456);
        tests_run++;
        if (r_rdata !== 32'h00000056) begin tests_failed++; $display("FAIL lb_lane0: got %h want 00000056", r_rdata); end
    endtask

    task automatic test_store();
        access(1'b1, 3'b001, 32'h102, 32'hABCD1234, 1, 32'hFFFFFFFF);
        tests_run++;
        if ({r_we, r_mask} !== 5'b11100 || r_wdata !== 32'h12341234) begin
            tests_failed++; $display("FAIL sh_bus: got we %b mask %b wdata %h want 1 1100 12341234", r_we, r_mask, r_wdata);
        end
        tests_run++;
        if (r_rdata !== 32'd0 || r_err !== 1'b0) begin
            tests_failed++; $display("FAIL sh_resp: got %h err %b want 00000000 err 0", r_rdata, r_err);
        end
        access(1'b1, 3'b000, 32'h101, 32'h0000005A, 2, 32'd0);
        tests_run++;
        if (r_mask !== 4'b0010 || r_wdata !== 32'h5A5A5A5A || r_addr !== 30'h40) begin
            tests_failed++; $display("FAIL sb_bus: got mask %b wdata %h addr %h want 0010 5a5a5a5a 40", r_mask, r_wdata, r_addr);
        end
        access(1'b1, 3'b010, 32'h104, 32'h11223344, 1, 32'd0);
        tests_run++;
        if (r_mask !== 4'b1111 || r_wdata !== 32'h11223344 || r_addr !== 30'h41) begin
            tests_failed++; $display("FAIL sw_bus: got mask %b wdata %h addr %h want 1111 11223344 41", r_mask, r_wdata, r_addr);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
        logic        sts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ads [4] = '{32'h102, 32'h100, 32'h100, 32'h101};
        for (int i = 0; i < 4; i++) begin
            access(sts[i], f3s[i], ads[i], 32'h55, 1, 32'hFFFFFFFF);
            tests_run++;
            if (r_req_cycles !== 0 || r_lat !== 1 || r_err !== 1'b1 || r_rdata !== 32'd0) begin
                tests_failed++;
                $display("FAIL err_case%0d: got reqcyc %0d lat %0d err %b rdata %h want 0 1 1 00000000",
                         i, r_req_cycles, r_lat, r_err, r_rdata);
            end
        end
    endtask

    task automatic test_timeout();
        access(1'b0, 3'b010, 32'h300, 32'd0, 0, 32'd0);
        tests_run++;
        if (r_req_cycles !== 15 || r_lat !== 16) begin
            tests_failed++; $display("FAIL to_cycles: got reqcyc %0d lat %0d want 15 16", r_req_cycles, r_lat);
        end
        tests_run++;
        if (r_err !== 1'b1 || r_rdata !== 32'd0) begin
            tests_failed++; $display("FAIL to_err: got err %b rdata %h want 1 00000000", r_err, r_rdata);
        end
        access(1'b0, 3'b010, 32'h300, 32'd0, 15, 32'hCAFEF00D);
        tests_run++;
        if (r_err !== 1'b0 || r_rdata !== 32'hCAFEF00D || r_lat !== 16) begin
            tests_failed++; $display("FAIL to_ack15: got err %b rdata %h lat %0d want 0 cafef00d 16", r_err, r_rdata, r_lat);
        end
    endtask

    task automatic test_idle_ack_and_hold();
        logic stray;
        stray = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || !req_ready || mem_req) stray = 1'b1;
        end
        mem_ack = 1'b0;
        tests_run++;
        if (stray !== 1'b0) begin tests_failed++; $display("FAIL idle_ack: got stray %b want 0", stray); end
        tests_run++;
        if (resp_rdata !== 32'hCAFEF00D || resp_err !== 1'b0) begin
            tests_failed++; $display("FAIL resp_hold: got %h err %b want cafef00d err 0", resp_rdata, resp_err);
        end
    endtask

    task automatic test_reset_mid_access();
        logic seen_resp;
        seen_resp = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre: got mem_req %b want 1", mem_req); end
        resetn = 1'b0;
        #1;
        tests_run++;
        if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_drop: got mem_req %b want 0", mem_req); end
        @(negedge clk);
        resetn  = 1'b1;
        mem_ack = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        mem_ack = 1'b0;
        tests_run++;
        if (seen_resp !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_noresp: got resp seen %b want 0", seen_resp); end
        access(1'b0, 3'b010, 32'h200, 32'd0, 2, 32'h13579BDF);
        tests_run++;
        if (r_rdata !== 32'h13579BDF || r_err !== 1'b0 || r_lat !== 3) begin
            tests_failed++; $display("FAIL rst_mid_after: got %h err %b lat %0d want 13579bdf 0 3", r_rdata, r_err, r_lat);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_errors();
        test_timeout();
        test_idle_ack_and_hold();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
